ltl_prog_automata: RTL and testbench
====================================

LTL_PROG_AUTOMATA -- requirements
Module: ltl_prog_automata

Interface
REQ-001 SHALL have parameter NUM_STE, default 16: number of state-transition elements (2..32).
REQ-002 SHALL have parameter SYM_W, default 8: symbol width in bits.
REQ-003 SHALL have parameter NUM_INT, default 8: match intervals per STE (1..16).
REQ-004 SHALL have parameter CNT_W, default 32: symbol-counter width.
REQ-005 SHALL have port clk, input, 1: the only clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-007 SHALL have port run, input, 1: consume `symbols` this cycle.
REQ-008 SHALL have port symbols, input, SYM_W: input symbol.
REQ-009 SHALL have port cfg_we, input, 1: configuration write strobe.
REQ-010 SHALL have port cfg_sel, input, 2: target; 0 = interval, 1 = edge row, 2 = STE flags.
REQ-011 SHALL have port cfg_ste, input, $clog2(NUM_STE): target STE index.
REQ-012 SHALL have port cfg_idx, input, $clog2(NUM_INT): interval slot (sel 0 only).
REQ-013 SHALL have port cfg_wdata, input, max(2*SYM_W+1, NUM_STE): write payload.
REQ-014 SHALL have port cfg_err, output, 1: one-cycle pulse when a write is rejected.
REQ-015 SHALL have port active, output, NUM_STE: current active-state vector.
REQ-016 SHALL have port rpt_valid, output, 1: report record held.
REQ-017 SHALL have port rpt_ready, input, 1: consumer accepts the report.
REQ-018 SHALL have port rpt_vec, output, NUM_STE: the reporting STEs.
REQ-019 SHALL have port rpt_pos, output, CNT_W: symbol index of the report (0-based).
REQ-020 SHALL have port rpt_ovf, output, 1: sticky flag; a report was dropped.

Function
REQ-021 Interval write (sel 0) SHALL store {valid = wdata[2*SYM_W], hi = wdata[2*SYM_W-1:SYM_W], lo = wdata[SYM_W-1:0]}.
REQ-022 Edge-row write (sel 1) SHALL store wdata[NUM_STE-1:0] as row cfg_ste; bit j set means the edge cfg_ste -> j exists.
REQ-023 Flags write (sel 2) SHALL store wdata[2:0] = {report_en, all_input_start, start_of_data_start}.
REQ-024 A write with cfg_we=1 while run=1, or with sel=3, SHALL be ignored and SHALL pulse cfg_err on the next cycle.
REQ-025 match[i] SHALL be combinational: 1 if any valid interval k of STE i satisfies lo <= symbols <= hi (inclusive, unsigned).
REQ-026 An interval with lo > hi SHALL never match.
REQ-027 enable[i] SHALL be the OR of:
- active[j] & edge[j][i], for any j;
- all_input_start[i];
- start_of_data_start[i] & sod.
REQ-028 sod SHALL be 1 on the first run=1 cycle after reset, and 0 otherwise.
REQ-029 When run=1, active[i] SHALL load enable[i] & match[i] on the clock edge; the one-cycle latency is symbol-to-active.
REQ-030 When run=0, active, the symbol counter and the sod state SHALL hold.
REQ-031 The symbol counter SHALL increment on each run=1 cycle and wrap from 2^CNT_W-1 to 0.
REQ-032 hit SHALL equal the registered active & report_en; it is evaluated one cycle after its symbol.
REQ-033 rpt_pos SHALL equal the counter value at which the reporting symbol was consumed.
REQ-034 Report buffer:
- hit != 0 with buffer empty, or with rpt_valid & rpt_ready: SHALL load rpt_vec and rpt_pos and set rpt_valid.
- hit != 0 with rpt_valid & !rpt_ready: SHALL drop the new report, keep the held record and set rpt_ovf.
- rpt_valid & rpt_ready with hit == 0: SHALL clear rpt_valid.
REQ-035 While rpt_valid=1 and rpt_ready=0, rpt_vec and rpt_pos SHALL be stable.
REQ-036 rpt_ovf SHALL clear only on reset.

Reset
REQ-037 Reset SHALL clear active, rpt_valid, rpt_vec, rpt_pos, rpt_ovf, cfg_err and the counter to 0, and re-arm sod.
REQ-038 Reset SHALL NOT clear configuration, so a programmed automaton survives a restart.
REQ-039 Reset asserted mid-stream SHALL take priority over run, cfg_we and the report handshake in the same cycle.
REQ-040 After power-up, before any configuration write, all interval valid bits, edges and flags SHALL read as 0.
REQ-041 The first run cycle after reset deassertion SHALL see sod=1.

Verification
REQ-042 Chain program:
- STE0 start_of_data_start, interval [0,15], edge 0->1;
- STE1 interval [16,31], report_en;
- symbols 5,20 -> active=0x1 then 0x2; rpt_valid=1, rpt_vec=0x2, rpt_pos=1.
REQ-043 Back-pressure:
- all_input_start STE reporting on 0xFF, rpt_ready=0;
- symbols FF,FF,FF -> rpt_pos=0 held, rpt_ovf=1;
- then rpt_ready=1 -> next record rpt_pos=2.
REQ-044 Stall: run toggling 1,0,0,1 with a 2-symbol match -> the report is identical to the contiguous-run result, and the counter has advanced by 2.
REQ-045 Config guard: cfg_we=1 while run=1 -> cfg_err pulses once, the table is unchanged, and subsequent matching is unaffected.
REQ-046 Reset mid-operation:
- reset during active=0x3 and rpt_valid=1 -> all outputs 0;
- replaying the same stream reproduces the same reports without reprogramming.
REQ-047 Boundaries:
- interval [0,255] matches every symbol;
- interval lo=9, hi=3 never matches;
- counter preloaded near wrap with CNT_W=4 -> rpt_pos wraps 15 -> 0.

Source files
------------

// File: rtl/ltl_prog_automata.sv
// Programmable NFA of state-transition elements: per-STE symbol intervals, an edge
// matrix and start/report flags, with a one-deep report buffer and overflow flag.
module ltl_prog_automata #(
    parameter int NUM_STE = 16,
    parameter int SYM_W   = 8,
    parameter int NUM_INT = 8,
    parameter int CNT_W   = 32,
    localparam int STE_W  = (NUM_STE > 1) ? $clog2(NUM_STE) : 1,
    localparam int IDX_W  = (NUM_INT > 1) ? $clog2(NUM_INT) : 1,
    localparam int WD_W   = (2*SYM_W+1 > NUM_STE) ? 2*SYM_W+1 : NUM_STE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [SYM_W-1:0]   symbols,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [STE_W-1:0]   cfg_ste,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [WD_W-1:0]    cfg_wdata,
    output logic               cfg_err,
    output logic [NUM_STE-1:0] active,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [NUM_STE-1:0] rpt_vec,
    output logic [CNT_W-1:0]   rpt_pos,
    output logic               rpt_ovf
);

    typedef enum logic [1:0] {
        SEL_INT   = 2'd0,
        SEL_EDGE  = 2'd1,
        SEL_FLAGS = 2'd2,
        SEL_RSVD  = 2'd3
    } cfg_sel_e;

    // Configuration has no reset so a programmed automaton survives a restart;
    // it relies on the device clearing registers at power-up.
    logic [SYM_W-1:0]   r_lo   [NUM_STE][NUM_INT];
    logic [SYM_W-1:0]   r_hi   [NUM_STE][NUM_INT];
    logic [NUM_INT-1:0] r_ival [NUM_STE];
    logic [NUM_STE-1:0] r_edge [NUM_STE];
    logic [NUM_STE-1:0] r_rep_en;
    logic [NUM_STE-1:0] r_ais;
    logic [NUM_STE-1:0] r_sods;

    logic [NUM_STE-1:0] r_active;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_hit_pos;
    logic               r_hit_pend;
    logic               r_sod;
    logic               r_rpt_valid;
    logic [NUM_STE-1:0] r_rpt_vec;
    logic [CNT_W-1:0]   r_rpt_pos;
    logic               r_rpt_ovf;
    logic               r_cfg_err;

    cfg_sel_e           w_sel;
    logic               w_cfg_ok;
    logic               w_cfg_bad;
    logic [NUM_STE-1:0] w_match;
    logic [NUM_STE-1:0] w_enable;
    logic [NUM_STE-1:0] w_hit;
    logic               w_hit_any;

    assign w_sel     = cfg_sel_e'(cfg_sel);
    assign w_cfg_bad = cfg_we & (run | (w_sel == SEL_RSVD));
    assign w_cfg_ok  = cfg_we & ~run & (w_sel != SEL_RSVD);

    always_ff @(posedge clk) begin
        if (!reset && w_cfg_ok) begin
            case (w_sel)
                SEL_INT: begin
                    r_lo[cfg_ste][cfg_idx]   <= cfg_wdata[SYM_W-1:0];
                    r_hi[cfg_ste][cfg_idx]   <= cfg_wdata[2*SYM_W-1:SYM_W];
                    r_ival[cfg_ste][cfg_idx] <= cfg_wdata[2*SYM_W];
                end
                SEL_EDGE:  r_edge[cfg_ste] <= cfg_wdata[NUM_STE-1:0];
                SEL_FLAGS: {r_rep_en[cfg_ste], r_ais[cfg_ste], r_sods[cfg_ste]} <= cfg_wdata[2:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < NUM_STE; i++) begin
            for (int unsigned k = 0; k < NUM_INT; k++) begin
                if (r_ival[i][k] && (symbols >= r_lo[i][k]) && (symbols <= r_hi[i][k]))
                    w_match[i] = 1'b1;
            end
        end
    end

    // Each active STE contributes its whole outgoing edge row.
    always_comb begin
        w_enable = r_ais | (r_sods & {NUM_STE{r_sod}});
        for (int unsigned j = 0; j < NUM_STE; j++) begin
            if (r_active[j])
                w_enable = w_enable | r_edge[j];
        end
    end

    // Reports only in the cycle right after a consumed symbol, so stalls never repeat one.
    assign w_hit     = r_hit_pend ? (r_active & r_rep_en) : '0;
    assign w_hit_any = |w_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active    <= '0;
            r_cnt       <= '0;
            r_hit_pos   <= '0;
            r_hit_pend  <= 1'b0;
            r_sod       <= 1'b1;
            r_rpt_valid <= 1'b0;
            r_rpt_vec   <= '0;
            r_rpt_pos   <= '0;
            r_rpt_ovf   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err  <= w_cfg_bad;
            r_hit_pend <= run;
            if (run) begin
                r_active  <= w_enable & w_match;
                r_hit_pos <= r_cnt;
                r_cnt     <= r_cnt + CNT_W'(1);
                r_sod     <= 1'b0;
            end
            if (w_hit_any && (!r_rpt_valid || rpt_ready)) begin
                r_rpt_valid <= 1'b1;
                r_rpt_vec   <= w_hit;
                r_rpt_pos   <= r_hit_pos;
            end else if (w_hit_any) begin
                r_rpt_ovf <= 1'b1;
            end else if (r_rpt_valid && rpt_ready) begin
                r_rpt_valid <= 1'b0;
            end
        end
    end

    assign cfg_err   = r_cfg_err;
    assign active    = r_active;
    assign rpt_valid = r_rpt_valid;
    assign rpt_vec   = r_rpt_vec;
    assign rpt_pos   = r_rpt_pos;
    assign rpt_ovf   = r_rpt_ovf;

endmodule

// File: tb/tb_ltl_prog_automata.sv
// Bench for ltl_prog_automata: directed scenarios plus random streams checked against
// a behavioural model of the automaton and report buffer (second DUT with CNT_W=4).
module tb_ltl_prog_automata;

    logic        clk = 1'b0;
    logic        reset, run, cfg_we, rpt_ready;
    logic [7:0]  symbols;
    logic [1:0]  cfg_sel;
    logic [3:0]  cfg_ste;
    logic [2:0]  cfg_idx;
    logic [16:0] cfg_wdata;

    logic        cfg_err, rpt_valid, rpt_ovf;
    logic [15:0] active, rpt_vec;
    logic [31:0] rpt_pos;
    logic        cfg_err4, rpt_valid4, rpt_ovf4;
    logic [15:0] active4, rpt_vec4;
    logic [3:0]  rpt_pos4;

    always #5 clk = ~clk;

    ltl_prog_automata dut (
        .clk(clk), .reset(reset), .run(run), .symbols(symbols),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ste(cfg_ste), .cfg_idx(cfg_idx),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .active(active),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_vec(rpt_vec),
        .rpt_pos(rpt_pos), .rpt_ovf(rpt_ovf)
    );

    ltl_prog_automata #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .run(run), .symbols(symbols),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ste(cfg_ste), .cfg_idx(cfg_idx),
        .cfg_wdata(cfg_wdata), .cfg_err(cfg_err4), .active(active4),
        .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready), .rpt_vec(rpt_vec4),
        .rpt_pos(rpt_pos4), .rpt_ovf(rpt_ovf4)
    );

    // Reference model state
    logic [7:0]  m_lo [16][8];
    logic [7:0]  m_hi [16][8];
    bit          m_val [16][8];
    logic [15:0] m_edge [16];
    logic [15:0] m_rep, m_ais, m_sods;
    logic [15:0] m_active, m_rvec;
    logic [31:0] m_cnt, m_rpos, m_ppos;
    bit          m_sod, m_pend, m_rv, m_ovf, m_err;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit m_match(int s, logic [7:0] sym);
        for (int k = 0; k < 8; k++)
            if (m_val[s][k] && sym >= m_lo[s][k] && sym <= m_hi[s][k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [15:0] hit;
        logic [15:0] nxt;
        if (reset) begin
            m_active = '0; m_cnt = '0; m_sod = 1'b1; m_pend = 1'b0; m_ppos = '0;
            m_rv = 1'b0; m_rvec = '0; m_rpos = '0; m_ovf = 1'b0; m_err = 1'b0;
        end else begin
            hit = m_pend ? (m_active & m_rep) : 16'h0;
            if (hit != 16'h0) begin
                if (!m_rv || rpt_ready) begin
                    m_rv = 1'b1; m_rvec = hit; m_rpos = m_ppos;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_rv && rpt_ready) begin
                m_rv = 1'b0;
            end
            m_err = cfg_we && (run || cfg_sel == 2'd3);
            if (cfg_we && !run && cfg_sel != 2'd3) begin
                case (cfg_sel)
                    2'd0: begin
                        m_lo[cfg_ste][cfg_idx]  = cfg_wdata[7:0];
                        m_hi[cfg_ste][cfg_idx]  = cfg_wdata[15:8];
                        m_val[cfg_ste][cfg_idx] = cfg_wdata[16];
                    end
                    2'd1: m_edge[cfg_ste] = cfg_wdata[15:0];
                    default: begin
                        m_rep[cfg_ste]  = cfg_wdata[2];
                        m_ais[cfg_ste]  = cfg_wdata[1];
                        m_sods[cfg_ste] = cfg_wdata[0];
                    end
                endcase
            end
            m_pend = run;
            if (run) begin
                for (int i = 0; i < 16; i++) begin
                    bit en;
                    en = m_ais[i] || (m_sods[i] && m_sod);
                    for (int j = 0; j < 16; j++)
                        if (m_active[j] && m_edge[j][i]) en = 1'b1;
                    nxt[i] = en && m_match(i, symbols);
                end
                m_active = nxt;
                m_ppos   = m_cnt;
                m_cnt    = m_cnt + 1;
                m_sod    = 1'b0;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("active", active, m_active);
        chk("rpt_valid", rpt_valid, m_rv);
        chk("rpt_vec", rpt_vec, m_rvec);
        chk("rpt_pos", rpt_pos, m_rpos);
        chk("rpt_ovf", rpt_ovf, m_ovf);
        chk("cfg_err", cfg_err, m_err);
        chk("rpt_pos4", rpt_pos4, m_rpos[3:0]);
        chk("rpt_valid4", rpt_valid4, m_rv);
    endtask

    task automatic idle(int n);
        run = 1'b0; cfg_we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic feed(logic [7:0] s);
        run = 1'b1; symbols = s;
        tick();
        run = 1'b0;
    endtask

    task automatic wr(logic [1:0] sel, int ste, int idx, logic [16:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ste = 4'(ste); cfg_idx = 3'(idx); cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wr_int(int ste, int idx, bit v, logic [7:0] lo, logic [7:0] hi);
        wr(2'd0, ste, idx, {v, hi, lo});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int s = 0; s < 16; s++) begin
            wr(2'd2, s, 0, 17'h0);
            wr(2'd1, s, 0, 17'h0);
            for (int k = 0; k < 8; k++) wr(2'd0, s, k, 17'h0);
        end
    endtask

    task automatic prog_chain();
        wr_int(0, 0, 1'b1, 8'd0, 8'd15);
        wr(2'd1, 0, 0, 17'h2);
        wr(2'd2, 0, 0, 17'h1);
        wr_int(1, 0, 1'b1, 8'd16, 8'd31);
        wr(2'd2, 1, 0, 17'h4);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; cfg_we = 1'b0; rpt_ready = 1'b0;
        symbols = '0; cfg_sel = '0; cfg_ste = '0; cfg_idx = '0; cfg_wdata = '0;
        for (int s = 0; s < 16; s++) begin
            m_edge[s] = '0;
            for (int k = 0; k < 8; k++) begin
                m_lo[s][k] = '0; m_hi[s][k] = '0; m_val[s][k] = 1'b0;
            end
        end
        m_rep = '0; m_ais = '0; m_sods = '0;

        tick(); tick();
        reset = 1'b0;
        chk("rst_active", active, 16'h0);
        chk("rst_valid", rpt_valid, 1'b0);

        // Unprogrammed automaton never activates
        repeat (8) feed(8'($urandom));
        chk("unconfig_active", active, 16'h0);

        // Chain program
        prog_chain();
        do_reset();
        feed(8'd5);
        chk("chain_a0", active, 16'h1);
        feed(8'd20);
        chk("chain_a1", active, 16'h2);
        idle(1);
        chk("chain_valid", rpt_valid, 1'b1);
        chk("chain_vec", rpt_vec, 16'h2);
        chk("chain_pos", rpt_pos, 32'd1);

        // Reset mid-operation, then replay
        wr(2'd2, 0, 0, 17'h3);
        wr_int(1, 1, 1'b1, 8'd0, 8'd15);
        do_reset();
        feed(8'd5); feed(8'd5); idle(1);
        chk("mid_active", active, 16'h3);
        chk("mid_valid", rpt_valid, 1'b1);
        do_reset();
        chk("mrst_active", active, 16'h0);
        chk("mrst_valid", rpt_valid, 1'b0);
        chk("mrst_vec", rpt_vec, 16'h0);
        chk("mrst_pos", rpt_pos, 32'd0);
        feed(8'd5); feed(8'd5); idle(1);
        chk("replay_vec", rpt_vec, 16'h2);
        chk("replay_pos", rpt_pos, 32'd1);

        // Stall: run 1,0,0,1
        wr(2'd2, 0, 0, 17'h1);
        wr_int(1, 1, 1'b0, 8'd0, 8'd0);
        do_reset();
        feed(8'd5); idle(2); feed(8'd20); idle(1);
        chk("stall_vec", rpt_vec, 16'h2);
        chk("stall_pos", rpt_pos, 32'd1);

        // Config guard: write during run is rejected
        do_reset();
        run = 1'b1; symbols = 8'd5;
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_ste = 4'd1; cfg_wdata = 17'h0;
        tick();
        cfg_we = 1'b0; run = 1'b0;
        chk("guard_err", cfg_err, 1'b1);
        feed(8'd20);
        chk("guard_err_clr", cfg_err, 1'b0);
        idle(1);
        chk("guard_vec", rpt_vec, 16'h2);
        wr(2'd3, 0, 0, 17'h1FFFF);
        chk("sel3_err", cfg_err, 1'b1);

        // Back-pressure
        clear_cfg();
        wr_int(2, 0, 1'b1, 8'hFF, 8'hFF);
        wr(2'd2, 2, 0, 17'h6);
        do_reset();
        rpt_ready = 1'b0;
        feed(8'hFF); feed(8'hFF); feed(8'hFF);
        chk("bp_pos", rpt_pos, 32'd0);
        chk("bp_ovf", rpt_ovf, 1'b1);
        chk("bp_vec", rpt_vec, 16'h4);
        rpt_ready = 1'b1;
        idle(1);
        chk("bp_next_pos", rpt_pos, 32'd2);
        chk("bp_next_valid", rpt_valid, 1'b1);
        idle(1);
        chk("bp_drain", rpt_valid, 1'b0);
        chk("bp_ovf_sticky", rpt_ovf, 1'b1);

        // Boundaries: full range and inverted interval
        wr_int(3, 0, 1'b1, 8'd0, 8'd255);
        wr(2'd2, 3, 0, 17'h6);
        wr_int(4, 0, 1'b1, 8'd9, 8'd3);
        wr(2'd2, 4, 0, 17'h6);
        do_reset();
        feed(8'd0);   chk("full_0", active[3], 1'b1);   chk("inv_0", active[4], 1'b0);
        feed(8'd255); chk("full_255", active[3], 1'b1); chk("inv_255", active[4], 1'b0);
        feed(8'd3);   chk("inv_3", active[4], 1'b0);
        feed(8'd9);   chk("inv_9", active[4], 1'b0);
        repeat (12) begin
            feed(8'($urandom));
            chk("full_rand", active[3], 1'b1);
            chk("inv_rand", active[4], 1'b0);
        end

        // Counter wrap on the 4-bit instance
        do_reset();
        rpt_ready = 1'b1;
        repeat (17) feed(8'($urandom));
        chk("wrap_pos15", rpt_pos4, 4'd15);
        idle(1);
        chk("wrap_pos0", rpt_pos4, 4'd0);
        chk("wrap_pos16", rpt_pos, 32'd16);

        // Random programs and streams
        for (int ep = 0; ep < 4; ep++) begin
            repeat (30) begin
                case ($urandom_range(0, 2))
                    0: wr_int($urandom_range(0, 15), $urandom_range(0, 7), 1'($urandom),
                              8'($urandom), 8'($urandom));
                    1: wr(2'd1, $urandom_range(0, 15), 0, 17'($urandom & $urandom & $urandom));
                    default: wr(2'd2, $urandom_range(0, 15), 0, 17'($urandom_range(0, 7)));
                endcase
            end
            do_reset();
            repeat (300) begin
                reset     = ($urandom_range(0, 63) == 0);
                run       = ($urandom_range(0, 3) != 0);
                symbols   = 8'($urandom);
                rpt_ready = 1'($urandom);
                cfg_we    = ($urandom_range(0, 31) == 0);
                cfg_sel   = 2'($urandom);
                cfg_ste   = 4'($urandom);
                cfg_idx   = 3'($urandom);
                cfg_wdata = 17'($urandom);
                tick();
            end
            reset = 1'b0; run = 1'b0; cfg_we = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
